fx2_cmd_responder: RTL and testbench
====================================

Name: fx2_cmd_responder

Overview:
- Device-side responder for the host command channel carried over the FX2 slave-FIFO link.
- Consumes command bytes strobed out by the FX2 bidirectional interface (cmd/cmd_wr) and parses framed register read and write commands.
- Drives a 32-bit register bus into the timetag core.
- Returns framed reply bytes to the FX2 interface over its reply_rdy/reply_ack/reply_end handshake.

Parameters:
TIMEOUT_CYCLES, 65535, max idle cycles between bytes of one command before abort (16-bit counter, must be >=1)
RD_LATENCY, 1, cycles from reg_rd pulse to reg_rdata valid (1..4)

Ports:
fx2_clk  input  1  sole clock
reset_n  input  1  asynchronous active-low reset
cmd  input  8  command byte from FX2 interface
cmd_wr  input  1  one-cycle strobe, cmd valid
reg_addr  output  8  register address
reg_wdata  output  32  register write data
reg_wr  output  1  one-cycle write strobe
reg_rd  output  1  one-cycle read strobe
reg_rdata  input  32  read data, valid RD_LATENCY cycles after reg_rd
reply  output  8  reply byte
reply_rdy  output  1  reply byte valid
reply_ack  input  1  consumer accepts byte when high with reply_rdy
reply_end  output  1  high with last byte of a reply frame
cmd_timeout  output  1  one-cycle pulse on inter-byte timeout abort
cmd_dropped  output  1  one-cycle pulse when a cmd byte is discarded

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including reg_addr, reg_wdata, reply, flags and counters.
- Command frame: opcode byte, address byte, then 4 data bytes LSB-first for writes only.
- Opcode 0x00: NOP, no reply.
- Opcode 0x01: READ.
- Opcode 0x02: WRITE.
- Any other opcode: error reply.
- States: IDLE, ADDR, DATA, EXEC_WR, EXEC_RD, REPLY.
- IDLE + cmd_wr:
  - 0x00 -> stay IDLE.
  - 0x01/0x02 -> ADDR, opcode latched.
  - Other -> REPLY with one byte 0x01, reply_end=1.
- ADDR + cmd_wr: reg_addr<=cmd.
  - READ -> EXEC_RD.
  - WRITE -> DATA with byte index 0.
- DATA + cmd_wr: reg_wdata[8*i+7:8*i]<=cmd, i increments.
  - After i=3 is stored -> EXEC_WR.
- EXEC_WR, when final data byte strobe is at cycle N:
  - reg_wr=1 for exactly cycle N+1.
  - REPLY at N+2: reply=0x00 (status OK), reply_end=1.
- EXEC_RD, when address strobe is at cycle N:
  - reg_rd=1 for exactly cycle N+1.
  - reg_rdata captured at cycle N+1+RD_LATENCY.
  - REPLY at N+2+RD_LATENCY with a 5-byte frame: 0x00, rdata[7:0], [15:8], [23:16], [31:24]; reply_end=1 only on the last byte.
- REPLY handshake:
  - reply/reply_rdy/reply_end are registered and held stable until reply_ack=1 in the same cycle as reply_rdy=1.
  - Next byte is presented the cycle after acceptance; back-to-back acks give one byte per cycle.
  - After the last byte is accepted: reply_rdy=0, state IDLE.
  - reply_ack while reply_rdy=0 is ignored.
- Timeout:
  - Counter cleared on every accepted byte; counts only in ADDR and DATA.
  - On reaching TIMEOUT_CYCLES: cmd_timeout pulses, state -> IDLE, partial command discarded, no reply, no reg strobe.
  - A cmd_wr in the same cycle as expiry is accepted and counted as arrival; no timeout.
- Byte dropping: cmd_wr in EXEC_WR, EXEC_RD or REPLY discards the byte and pulses cmd_dropped that cycle; the frame in progress is unaffected.
- reg_addr and reg_wdata hold their last values between commands.
- reg_wr and reg_rd are never high simultaneously.
- Reset mid-reply: reply_rdy drops immediately (asynchronous).

Test Plan:
- WRITE 02,10,78,56,34,12 on consecutive cycles -> reg_wr single pulse with reg_addr=0x10, reg_wdata=0x12345678; reply 0x00 with reply_end=1; back to IDLE.
- READ 01,20, reg_rdata=0xDEADBEEF, RD_LATENCY=1, reply_ack tied 1 -> reg_rd pulse, replies 00,EF,BE,AD,DE on 5 consecutive cycles, reply_end only on DE.
- Same READ with reply_ack low for 10 cycles, then pulsed every 3rd cycle -> reply bytes held stable while not acked; no byte lost or duplicated.
- Opcode 0x7F -> single reply 0x01 with reply_end=1, no reg strobes; opcode 0x00 -> no reply, no strobes.
- TIMEOUT_CYCLES=8: send 02,10,AA then idle 8 cycles -> cmd_timeout pulse, no reg_wr; a following READ 01,10 completes normally.
- Send cmd byte 0x55 while a READ reply is pending unacked -> cmd_dropped pulse, reply frame intact; assert reset_n=0 mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/fx2_cmd_responder.sv
// Host command responder on the FX2 slave-FIFO link: parses framed register
// read/write commands, drives the 32-bit register bus into the timetag core
// and returns framed reply bytes over a ready/ack handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an opcode byte
// ADDR    | opcode latched, waiting for the address byte
// DATA    | collecting the four write-data bytes, LSB first
// EXEC_WR | one-cycle register write strobe
// EXEC_RD | read strobe, then wait RD_LATENCY cycles for reg_rdata
// REPLY   | presenting reply bytes until the last one is accepted
module fx2_cmd_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic        fx2_clk,
    input  logic        reset_n,
    input  logic [7:0]  cmd,
    input  logic        cmd_wr,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [31:0] reg_rdata,
    output logic [7:0]  reply,
    output logic        reply_rdy,
    input  logic        reply_ack,
    output logic        reply_end,
    output logic        cmd_timeout,
    output logic        cmd_dropped
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        EXEC_WR = 3'd3,
        EXEC_RD = 3'd4,
        REPLY   = 3'd5
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAT_LAST = 3'(RD_LATENCY);

    state_t      state_q, state_d;
    logic        op_rd_q, op_rd_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  ridx_q, ridx_d;
    logic [15:0] tmo_q, tmo_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic [7:0]  reply_q, reply_d;
    logic        reply_rdy_q, reply_rdy_d;
    logic        reply_end_q, reply_end_d;
    logic        in_cmd;
    logic        tmo_hit;

    // Inter-byte idle counter: only runs while a command is partially received.
    always_comb begin
        in_cmd  = (state_q == ADDR) || (state_q == DATA);
        tmo_hit = in_cmd && !cmd_wr && (tmo_q == TMO_LAST);
        tmo_d   = 16'd0;
        if (in_cmd && !cmd_wr && !tmo_hit) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // Next-state, register-bus strobes and reply sequencing.
    always_comb begin
        state_d     = state_q;
        op_rd_d     = op_rd_q;
        idx_d       = idx_q;
        ridx_d      = ridx_q;
        lat_d       = lat_q;
        rdata_d     = rdata_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reply_d     = reply_q;
        reply_rdy_d = reply_rdy_q;
        reply_end_d = reply_end_q;
        reg_wr      = 1'b0;
        reg_rd      = 1'b0;
        cmd_timeout = 1'b0;
        cmd_dropped = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_wr) begin
                    case (cmd)
                        8'h00: state_d = IDLE;
                        8'h01: begin op_rd_d = 1'b1; state_d = ADDR; end
                        8'h02: begin op_rd_d = 1'b0; state_d = ADDR; end
                        default: begin
                            reply_d     = 8'h01;
                            reply_rdy_d = 1'b1;
                            reply_end_d = 1'b1;
                            state_d     = REPLY;
                        end
                    endcase
                end
            end
            ADDR: begin
                if (cmd_wr) begin
                    reg_addr_d = cmd;
                    if (op_rd_q) begin
                        lat_d   = 3'd0;
                        state_d = EXEC_RD;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = DATA;
                    end
                end else if (tmo_hit) begin
                    cmd_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            DATA: begin
                if (cmd_wr) begin
                    reg_wdata_d[{idx_q, 3'b000} +: 8] = cmd;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = EXEC_WR;
                    end
                end else if (tmo_hit) begin
                    cmd_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            EXEC_WR: begin
                cmd_dropped = cmd_wr;
                reg_wr      = 1'b1;
                reply_d     = 8'h00;
                reply_rdy_d = 1'b1;
                reply_end_d = 1'b1;
                state_d     = REPLY;
            end
            EXEC_RD: begin
                cmd_dropped = cmd_wr;
                reg_rd      = (lat_q == 3'd0);
                if (lat_q == LAT_LAST) begin
                    rdata_d     = reg_rdata;
                    reply_d     = 8'h00;
                    reply_rdy_d = 1'b1;
                    reply_end_d = 1'b0;
                    ridx_d      = 2'd0;
                    state_d     = REPLY;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            REPLY: begin
                cmd_dropped = cmd_wr;
                if (reply_ack && reply_rdy_q) begin
                    if (reply_end_q) begin
                        reply_d     = 8'h00;
                        reply_rdy_d = 1'b0;
                        reply_end_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        // ridx_q counts data bytes already shown; the next one is byte ridx_q.
                        reply_d     = rdata_q[{ridx_q, 3'b000} +: 8];
                        reply_end_d = (ridx_q == 2'd3);
                        ridx_d      = ridx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reply_rdy drops immediately on reset.
    always_ff @(posedge fx2_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_rd_q     <= 1'b0;
            idx_q       <= 2'd0;
            ridx_q      <= 2'd0;
            tmo_q       <= 16'd0;
            lat_q       <= 3'd0;
            rdata_q     <= 32'd0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 32'd0;
            reply_q     <= 8'd0;
            reply_rdy_q <= 1'b0;
            reply_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_rd_q     <= op_rd_d;
            idx_q       <= idx_d;
            ridx_q      <= ridx_d;
            tmo_q       <= tmo_d;
            lat_q       <= lat_d;
            rdata_q     <= rdata_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reply_q     <= reply_d;
            reply_rdy_q <= reply_rdy_d;
            reply_end_q <= reply_end_d;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reply     = reply_q;
    assign reply_rdy = reply_rdy_q;
    assign reply_end = reply_end_q;

endmodule

// File: tb/tb_fx2_cmd_responder.sv
// Directed bench for fx2_cmd_responder with reply/transaction scoreboards.
module tb_fx2_cmd_responder;

    localparam int TMO    = 8;
    localparam int RD_LAT = 1;

    logic        fx2_clk   = 1'b0;
    logic        reset_n   = 1'b0;
    logic [7:0]  cmd       = 8'h00;
    logic        cmd_wr    = 1'b0;
    logic        reply_ack = 1'b0;
    logic [31:0] rd_value  = 32'h0;
    logic [31:0] reg_rdata;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr, reg_rd;
    logic [7:0]  reply;
    logic        reply_rdy, reply_end, cmd_timeout, cmd_dropped;

    fx2_cmd_responder #(.TIMEOUT_CYCLES(TMO), .RD_LATENCY(RD_LAT)) dut (
        .fx2_clk(fx2_clk), .reset_n(reset_n), .cmd(cmd), .cmd_wr(cmd_wr),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .reply(reply), .reply_rdy(reply_rdy), .reply_ack(reply_ack),
        .reply_end(reply_end), .cmd_timeout(cmd_timeout), .cmd_dropped(cmd_dropped)
    );

    always #5 fx2_clk = ~fx2_clk;

    int checks = 0;
    int failures = 0;
    logic [8:0]  rep_q[$];
    logic [39:0] wr_q[$];
    logic [7:0]  rd_q[$];
    int          tmo_cnt = 0;
    int          drop_cnt = 0;
    logic        hold_q = 1'b0;
    logic [9:0]  hold_v = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register read model: data is valid only RD_LAT cycles after reg_rd.
    logic [3:0] rd_pipe;
    always @(posedge fx2_clk or negedge reset_n) begin
        if (!reset_n) rd_pipe <= '0;
        else          rd_pipe <= {rd_pipe[2:0], reg_rd};
    end
    assign reg_rdata = rd_pipe[RD_LAT-1] ? rd_value : 32'hBAD0_BAD0;

    // Scoreboard monitor sampling on the falling edge.
    always @(negedge fx2_clk) begin
        logic [8:0]  er;
        logic [39:0] ew;
        logic [7:0]  ea;
        if (reset_n) begin
            if (hold_q) chk("reply_hold", {reply_rdy, reply_end, reply}, hold_v);
            hold_q <= reply_rdy && !reply_ack;
            hold_v <= {reply_rdy, reply_end, reply};
            if (reply_rdy && reply_ack) begin
                chk("reply_queued", rep_q.size() > 0, 1);
                if (rep_q.size() > 0) begin
                    er = rep_q.pop_front();
                    chk("reply_byte", {reply_end, reply}, er);
                end
            end
            if (reg_wr) begin
                chk("wr_queued", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                    ew = wr_q.pop_front();
                    chk("wr_txn", {reg_rd, reg_addr, reg_wdata}, {1'b0, ew});
                end
            end
            if (reg_rd) begin
                chk("rd_queued", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) begin
                    ea = rd_q.pop_front();
                    chk("rd_txn", {reg_wr, reg_addr}, {1'b0, ea});
                end
            end
            if (cmd_timeout) tmo_cnt <= tmo_cnt + 1;
            if (cmd_dropped) drop_cnt <= drop_cnt + 1;
        end else begin
            hold_q <= 1'b0;
        end
    end

    task automatic send(input logic [7:0] b);
        cmd = b;
        cmd_wr = 1'b1;
        @(posedge fx2_clk); #1;
        cmd_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge fx2_clk); #1; end
    endtask

    task automatic push_read(input logic [7:0] a, input logic [31:0] v);
        rd_q.push_back(a);
        rep_q.push_back({1'b0, 8'h00});
        for (int k = 0; k < 4; k++) rep_q.push_back({k == 3, v[8*k +: 8]});
    endtask

    // mode 0: ack every cycle; mode 1: ack low 10 cycles, then every 3rd cycle.
    task automatic drain(input int mode, input string tag);
        int c;
        c = 0;
        while (c < 300 && !(rep_q.size() == 0 && !reply_rdy)) begin
            reply_ack = (mode == 0) ? 1'b1 : (c >= 10 && (c % 3) == 0);
            @(posedge fx2_clk); #1;
            c++;
        end
        reply_ack = 1'b0;
        chk({tag, "_drained"}, {rep_q.size() == 0, reply_rdy}, 2'b10);
    endtask

    task automatic wait_rdy(input string tag);
        int c;
        c = 0;
        while (!reply_rdy && c < 20) begin @(posedge fx2_clk); #1; c++; end
        chk(tag, reply_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        // Reset state
        #12;
        chk("reset_outs", {reg_addr, reg_wdata, reply, reply_rdy, reply_end, reg_wr, reg_rd,
                           cmd_timeout, cmd_dropped}, 64'd0);
        @(posedge fx2_clk); #1;
        reset_n = 1'b1;
        idle(2);

        // WRITE 02,10,78,56,34,12
        reply_ack = 1'b1;
        wr_q.push_back({8'h10, 32'h1234_5678});
        rep_q.push_back({1'b1, 8'h00});
        send(8'h02); send(8'h10); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        @(negedge fx2_clk); chk("wr_pulse", {reg_wr, reg_rd, reply_rdy}, 3'b100);
        @(posedge fx2_clk); #1;
        @(negedge fx2_clk); chk("wr_reply", {reply_rdy, reply_end, reply, reg_wr}, {2'b11, 8'h00, 1'b0});
        @(posedge fx2_clk); #1;
        @(negedge fx2_clk); chk("wr_done", {reg_wr, reply_rdy}, 2'b00);
        chk("wr_hold_regs", {reg_addr, reg_wdata}, {8'h10, 32'h1234_5678});
        @(posedge fx2_clk); #1;

        // READ 01,20 with ack tied high
        rd_value = 32'hDEAD_BEEF;
        push_read(8'h20, rd_value);
        send(8'h01); send(8'h20);
        @(negedge fx2_clk); chk("rd_pulse", {reg_rd, reg_wr}, 2'b10);
        @(posedge fx2_clk); #1;
        @(negedge fx2_clk); chk("rd_latency", {reg_rd, reply_rdy}, 2'b00);
        @(posedge fx2_clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge fx2_clk); chk("rd_burst", {reply_rdy, reply_end}, {1'b1, k == 4});
            @(posedge fx2_clk); #1;
        end
        @(negedge fx2_clk); chk("rd_after", reply_rdy, 0);
        chk("rd_sb_empty", rep_q.size() + rd_q.size(), 0);
        @(posedge fx2_clk); #1;

        // Same READ with a slow consumer
        reply_ack = 1'b0;
        push_read(8'h20, rd_value);
        send(8'h01); send(8'h20);
        drain(1, "slow_read");

        // Unknown opcode, then NOP
        reply_ack = 1'b1;
        rep_q.push_back({1'b1, 8'h01});
        send(8'h7F);
        @(negedge fx2_clk); chk("err_reply", {reply_rdy, reply_end, reply, reg_wr, reg_rd}, {2'b11, 8'h01, 2'b00});
        @(posedge fx2_clk); #1;
        @(negedge fx2_clk); chk("err_done", reply_rdy, 0);
        @(posedge fx2_clk); #1;
        send(8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge fx2_clk); chk("nop_quiet", {reply_rdy, reg_wr, reg_rd}, 3'b000);
            @(posedge fx2_clk); #1;
        end
        reply_ack = 1'b0;

        // Timeout after 02,10,AA and 8 idle cycles
        t0 = tmo_cnt;
        send(8'h02); send(8'h10); send(8'hAA);
        for (int i = 1; i <= 8; i++) begin
            @(negedge fx2_clk); chk("tmo_wait", cmd_timeout, i == 8);
            @(posedge fx2_clk); #1;
        end
        @(negedge fx2_clk); chk("tmo_after", {cmd_timeout, reg_wr, reply_rdy}, 3'b000);
        chk("tmo_count", tmo_cnt - t0, 1);
        @(posedge fx2_clk); #1;
        rd_value = 32'h8C4E_1A27;
        push_read(8'h10, rd_value);
        send(8'h01); send(8'h10);
        drain(0, "tmo_read");

        // Byte arriving exactly in the expiry cycle is accepted
        t0 = tmo_cnt;
        wr_q.push_back({8'h33, 32'h4433_2211});
        rep_q.push_back({1'b1, 8'h00});
        send(8'h02); send(8'h33);
        idle(TMO - 1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        drain(0, "late_wr");
        chk("late_no_tmo", tmo_cnt - t0, 0);
        chk("late_wr_sb", wr_q.size(), 0);

        // Byte dropped while a reply is pending
        rd_value = 32'h0F1E_2D3C;
        push_read(8'h44, rd_value);
        send(8'h01); send(8'h44);
        wait_rdy("drop_wait_rdy");
        t0 = drop_cnt;
        cmd = 8'h55;
        cmd_wr = 1'b1;
        @(negedge fx2_clk); chk("drop_pulse", cmd_dropped, 1);
        @(posedge fx2_clk); #1;
        cmd_wr = 1'b0;
        drain(1, "drop_frame");
        chk("drop_count", drop_cnt - t0, 1);
        idle(3);
        @(negedge fx2_clk); chk("drop_no_frame", {reply_rdy, reg_wr, reg_rd}, 3'b000);
        @(posedge fx2_clk); #1;

        // Reset asserted mid-reply
        push_read(8'h55, rd_value);
        send(8'h01); send(8'h55);
        wait_rdy("rst_wait_rdy");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid", {reg_addr, reg_wdata, reply, reply_rdy, reply_end, reg_wr, reg_rd,
                        cmd_timeout, cmd_dropped}, 64'd0);
        rep_q.delete();
        @(posedge fx2_clk); #1;
        reset_n = 1'b1;
        idle(1);
        wr_q.push_back({8'h5A, 32'hCAFE_0123});
        rep_q.push_back({1'b1, 8'h00});
        send(8'h02); send(8'h5A); send(8'h23); send(8'h01); send(8'hFE); send(8'hCA);
        drain(0, "post_rst_wr");
        chk("post_rst_sb", wr_q.size() + rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
